// File: rtl/pipe_pkg.sv
// Shared CPU pipeline definitions: datapath widths, reset vector and the
// instruction-queue entry layout used by the fetch stage.
package pipe_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;
  localparam logic [ADDR_W-1:0] INSTR_BYTES      = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] ins;
    logic [ADDR_W-1:0]  pc4;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, synchronous clear and occupancy
// count. The caller guarantees no push when full and no pop when empty.
module sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: the storage array is deliberately not reset; count gates validity,
  // so clearing data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: issues sequential word fetches under a credit limit, buffers
// returned words with their PC+4, and flushes wrong-path words on redirect.
module ifetch_queue
  import pipe_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               mem_req_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  input  logic               mem_ready_i,
  input  logic               mem_rvalid_i,
  input  logic [INSTR_W-1:0] mem_rdata_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] ins_o,
  output logic [ADDR_W-1:0]  pc4_o,
  input  logic               take_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_nxt;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     fifo_count;
  logic              credit;
  logic              accept;
  logic              push;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  // NOTE: every always_comb output gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    credit          = 1'b0;
    mem_req_o       = 1'b0;
    accept          = 1'b0;
    push            = 1'b0;
    pop             = 1'b0;
    outstanding_nxt = outstanding;

    // Buffered plus in-flight words never exceed the queue, so a push always fits.
    credit          = ((CW+1)'(fifo_count) + (CW+1)'(outstanding)) < (CW+1)'(DEPTH);
    mem_req_o       = rst_i & credit;
    accept          = mem_req_o & mem_ready_i;
    outstanding_nxt = outstanding + CW'(accept) - CW'(mem_rvalid_i);
    push            = mem_rvalid_i & (drop_cnt == '0) & ~redirect_i;
    pop             = valid_o & take_i & ~redirect_i;
  end

  assign push_entry = '{ins: mem_rdata_i, pc4: resp_pc + INSTR_BYTES};

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_pc    <= word_align(RESET_PC);
      resp_pc     <= word_align(RESET_PC);
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_i) begin
        // Everything still in flight after this edge is wrong-path.
        fetch_pc <= word_align(redirect_pc_i);
        resp_pc  <= word_align(redirect_pc_i);
        drop_cnt <= outstanding_nxt;
      end else begin
        if (accept) fetch_pc <= fetch_pc + INSTR_BYTES;
        if (mem_rvalid_i) begin
          if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
          else                resp_pc  <= resp_pc + INSTR_BYTES;
        end
      end
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_queue (
    .clk   (clk_i),
    .rst_n (rst_i),
    .clear (redirect_i),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count)
  );

  assign mem_addr_o = fetch_pc;
  assign valid_o    = (fifo_count != '0);
  assign ins_o      = head.ins;
  assign pc4_o      = head.pc4;

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised and directed bench for ifetch_queue, checked every cycle against
// a queue-based model of the fetch stage plus a small in-order memory.
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct { logic [31:0] addr; bit stale; } flight_t;
  typedef struct { logic [31:0] ins; logic [31:0] pc4; } ent_t;
  typedef struct { logic [31:0] data; int t; } rsp_t;

  logic        clk = 1'b0;
  logic        rst_i, mem_req_o, mem_ready_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_rdata_i, ins_o, pc4_o, redirect_pc_i;
  logic        valid_o, take_i, redirect_i;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ready_i   (mem_ready_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .valid_o       (valid_o),
    .ins_o         (ins_o),
    .pc4_o         (pc4_o),
    .take_i        (take_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
  );

  always #5 clk = ~clk;

  // model state
  flight_t     inf[$];
  ent_t        fq[$];
  rsp_t        mq[$];
  logic [31:0] m_fetch_pc = RESET_PC;
  int          last_t = 0;
  int          cyc = 0;

  // stimulus controls
  logic        rst_v = 1'b0, ready_v = 1'b0, take_v = 1'b0, redir_v = 1'b0;
  logic [31:0] redir_pc_v = '0;
  int          lat_v = 1;

  int          n_chk = 0, n_pass = 0, n_acc = 0;
  logic [31:0] pop_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    logic    exp_req;
    bit      rv;
    logic [31:0] rd;
    ent_t    e;
    flight_t f;
    rsp_t    r;
    int      t;
    rst_i = rst_v; mem_ready_i = ready_v; take_i = take_v;
    redirect_i = redir_v; redirect_pc_i = redir_pc_v;
    rv = 1'b0;
    rd = $urandom;
    if (rst_v && mq.size() > 0 && mq[0].t <= cyc) begin
      r  = mq.pop_front();
      rv = 1'b1;
      rd = r.data;
    end
    mem_rvalid_i = rv; mem_rdata_i = rd;
    #1;
    exp_req = rst_v && (fq.size() + inf.size() < DEPTH);
    check("mem_req", mem_req_o, exp_req);
    if (exp_req) check("mem_addr", mem_addr_o, m_fetch_pc);
    check("valid", valid_o, fq.size() > 0);
    if (fq.size() > 0) begin
      check("ins", ins_o, fq[0].ins);
      check("pc4", pc4_o, fq[0].pc4);
    end
    if (mem_req_o && ready_v) n_acc++;
    if (valid_o && take_v && !redir_v) pop_log.push_back(pc4_o);

    if (!rst_v) begin
      fq.delete(); inf.delete(); mq.delete();
      m_fetch_pc = RESET_PC;
      last_t = cyc;
    end else begin
      if (fq.size() > 0 && take_v && !redir_v) e = fq.pop_front();
      if (rv && inf.size() > 0) begin
        f = inf.pop_front();
        if (!f.stale && !redir_v) fq.push_back('{ins: rd, pc4: f.addr + 32'd4});
      end
      if (exp_req && ready_v) begin
        inf.push_back('{addr: m_fetch_pc, stale: 1'b0});
        t = (cyc + lat_v > last_t + 1) ? cyc + lat_v : last_t + 1;
        mq.push_back('{data: m_fetch_pc, t: t});
        last_t = t;
        m_fetch_pc += 32'd4;
      end
      if (redir_v) begin
        fq.delete();
        foreach (inf[i]) inf[i].stale = 1'b1;
        m_fetch_pc = redir_pc_v & 32'hFFFF_FFFC;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_v = 1'b0; redir_v = 1'b0;
    tick(); tick();
    rst_v = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (valid_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(name, valid_o, 1'b1);
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redir_v = 1'b1; redir_pc_v = pc;
    tick();
    redir_v = 1'b0;
  endtask

  initial begin
    int errs;
    rst_i = 1'b0; mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    take_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    repeat (2) @(negedge clk);

    // Reset, then 1-cycle memory streaming
    do_reset();
    check("reset_valid", valid_o, 1'b0);
    ready_v = 1'b1; take_v = 1'b1; lat_v = 1;
    tick();
    check("first_valid_lat", valid_o, 1'b0);
    tick();
    check("stream_valid", valid_o, 1'b1);
    check("stream_pc4_0", pc4_o, 32'd4);
    check("stream_ins_0", ins_o, 32'd0);
    tick();
    check("stream_pc4_1", pc4_o, 32'd8);
    check("stream_ins_1", ins_o, 32'd4);
    tick();
    check("stream_pc4_2", pc4_o, 32'd12);
    check("stream_ins_2", ins_o, 32'd8);

    // Stall with take_i=0: credits stop fetching at DEPTH
    do_reset();
    take_v = 1'b0; n_acc = 0;
    repeat (10) tick();
    check("stall_accepts", n_acc, DEPTH);
    check("stall_req_off", mem_req_o, 1'b0);
    take_v = 1'b1; pop_log.delete();
    repeat (12) tick();
    check("release_pops", pop_log.size() >= 11, 1'b1);
    for (int i = 0; i < 5; i++) check("release_order", pop_log[i], 32'(4 * (i + 1)));

    // Random ready, 3-cycle latency: strictly sequential stream
    do_reset();
    lat_v = 3; pop_log.delete();
    for (int i = 0; i < 5000 && pop_log.size() < 200; i++) begin
      ready_v = ($urandom_range(1) == 1);
      take_v  = ($urandom_range(3) != 0);
      tick();
    end
    check("seq_200_words", pop_log.size() >= 200, 1'b1);
    errs = 0;
    foreach (pop_log[i]) if (pop_log[i] !== 32'(4 * (i + 1))) errs++;
    check("seq_errors", errs, 0);

    // Redirect with 3 requests in flight
    do_reset();
    lat_v = 3; ready_v = 1'b1; take_v = 1'b0;
    tick(); tick();
    redirect_to(32'h100);
    take_v = 1'b1;
    wait_valid("redir_wait");
    check("redir_pc4", pc4_o, 32'h104);
    check("redir_ins", ins_o, 32'h100);

    // Redirect coinciding with push, pop and accept
    do_reset();
    lat_v = 1; ready_v = 1'b1; take_v = 1'b1;
    repeat (6) tick();
    redirect_to(32'h200);
    check("redir_busy_flush", valid_o, 1'b0);
    wait_valid("redir_busy_wait");
    check("redir_busy_pc4", pc4_o, 32'h204);

    // Address wrap and unaligned target
    redirect_to(32'hFFFF_FFFC);
    wait_valid("wrap_wait");
    check("wrap_ins", ins_o, 32'hFFFF_FFFC);
    check("wrap_pc4_0", pc4_o, 32'h0);
    tick();
    check("wrap_pc4_1", pc4_o, 32'h4);
    redirect_to(32'h103);
    wait_valid("align_wait");
    check("align_pc4", pc4_o, 32'h104);
    check("align_ins", ins_o, 32'h100);

    // Random mix of everything, including mid-stream resets
    for (int i = 0; i < 1500; i++) begin
      lat_v      = $urandom_range(4, 1);
      ready_v    = ($urandom_range(3) != 0);
      take_v     = ($urandom_range(9) < 7);
      redir_v    = ($urandom_range(99) < 4);
      redir_pc_v = ($urandom_range(1) == 1) ? $urandom : ($urandom & 32'h0000_0FFF);
      rst_v      = ($urandom_range(299) != 0);
      tick();
    end
    redir_v = 1'b0; rst_v = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction prefetch queue forming the fetch stage of the pipelined CPU, directly upstream of the IF/ID pipeline register. It issues sequential fetch requests to a variable-latency instruction memory and buffers returned words with their PC+4. It presents one instruction per cycle to IF/ID, holds under hazard stalls, and discards wrong-path words on a taken-branch redirect.

## Interface
- DEPTH, 4, queue entries and the maximum of (buffered + in-flight) fetches; power of two, 2..16
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  reset, synchronous, active-low
- mem_req_o  out  1  fetch request valid
- mem_addr_o  out  32  fetch address, word-aligned
- mem_ready_i  in  1  memory accepts request this cycle when mem_req_o=1
- mem_rvalid_i  in  1  response word valid; responses return in request order, at least 1 cycle after acceptance
- mem_rdata_i  in  32  response instruction word
- valid_o  out  1  ins_o/pc4_o hold a valid instruction
- ins_o  out  32  instruction at queue head
- pc4_o  out  32  address of head instruction + 4, feeds IF/ID upper word
- take_i  in  1  IF/ID consumes head this cycle (driven by IF/ID write enable)
- redirect_i  in  1  taken branch resolved (PCSrc)
- redirect_pc_i  in  32  branch target

## Operation
- State: fetch_pc, resp_pc (address of next kept response), queue (DEPTH × {ins, pc4}), count, outstanding, drop_cnt.
- Credit rule: mem_req_o = rst_i & (count + outstanding < DEPTH). Queue never overflows; any push always fits.
- mem_addr_o = fetch_pc. Accept (mem_req_o & mem_ready_i): fetch_pc += 4, outstanding += 1.
- Response (mem_rvalid_i): outstanding -= 1; if drop_cnt > 0 then drop_cnt -= 1 and word discarded; else push {mem_rdata_i, resp_pc+4}, resp_pc += 4.
- Pop: valid_o & take_i & ~redirect_i removes head. take_i while valid_o=0 ignored.
- Push and pop in the same cycle: count unchanged, order preserved.
- Redirect (highest priority): fetch_pc and resp_pc <= {redirect_pc_i[31:2], 2'b00}; queue emptied (count=0); drop_cnt <= outstanding after this cycle's accept/response updates, i.e. every request still in flight, including one accepted in the redirect cycle, is dropped; response arriving in redirect cycle is discarded regardless of drop_cnt.
- Redirect during drop: drop_cnt recomputed as above, never accumulated twice.
- Address arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- ins_o/pc4_o undefined-but-stable (hold last head) when valid_o=0; consumers qualify with valid_o.

## Timing
- Reset (rst_i=0 at an edge): fetch_pc=resp_pc=RESET_PC, count=outstanding=drop_cnt=0; valid_o=0; mem_req_o=0 while rst_i=0. Memory shares reset; no response is expected in the cycle after reset.
- Reset mid-operation discards queue and in-flight state identically.
- Latency: request accepted at cycle N, rvalid at N+1 → valid_o=1 at N+2 (queue output is registered; no bypass).
- Steady state with 1-cycle memory and DEPTH≥2: one instruction per cycle.
- Redirect at cycle R: valid_o=0 at R+1; mem_req_o for target may assert at R+1 only if credits allow (outstanding dropped responses still hold credits).

## Structure
- Shared package pipe_pkg: INSTR_W=32, ADDR_W=32, RESET_PC default, word-align helper constant.
- One sub-module: sync_fifo (DEPTH × 64 bits, push/pop/clear, count output); ifetch_queue owns PC, credit and drop logic.

## Test plan
- Reset then 1-cycle memory returning addr as data, take_i=1: valid_o at cycle 2, pc4_o = 4, 8, 12 … on consecutive cycles; ins_o = 0, 4, 8.
- take_i=0 for 10 cycles, DEPTH=4: exactly 4 requests accepted, mem_req_o then 0; release → 4 ordered words then streaming resumes with no gap beyond 1 cycle.
- mem_ready_i random 50%, 3-cycle rvalid latency: instruction stream strictly sequential, no loss or duplication over 200 words.
- Redirect to 32'h100 with 3 in flight: next 3 responses dropped, first valid_o shows pc4_o=32'h104; no stale word ever reaches valid_o.
- Redirect coinciding with push, pop and accept in the same cycle: queue empty next cycle, accepted request dropped, target fetched next.
- Redirect to 32'hFFFF_FFFC: pc4_o=0 then 4; redirect_pc_i=32'h103 fetches 32'h100.
